hcsr04_echo_capture: RTL

//   Front end for the HC-SR04 ranging path. Issues periodic trigger pulses and synchronises the raw echo input.

---
 rtl/hcsr04_echo_capture.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hcsr04_echo_capture.sv
// HC-SR04 ranging front end: periodic trigger, echo synchroniser, echo-width
// measurement with timeout, and a valid/ready result port with overrun flag.
module hcsr04_echo_capture #(
   parameter int TRIG_TICKS    = 120,
   parameter int PERIOD_TICKS  = 720000,
   parameter int TIMEOUT_TICKS = 360000,
   parameter int WIDTH         = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic             trig_pin,
   input  logic             echo_pin,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [WIDTH-1:0] meas_ticks,
   output logic             meas_timeout,
   output logic             overrun
);
   localparam logic [WIDTH-1:0] TRIG_LAST   = WIDTH'(TRIG_TICKS - 1);
   localparam logic [WIDTH-1:0] PERIOD_LAST = WIDTH'(PERIOD_TICKS - 1);
   localparam logic [WIDTH-1:0] WAIT_LAST   = WIDTH'(TIMEOUT_TICKS - 1);
   localparam logic [WIDTH-1:0] TIMEOUT_W   = WIDTH'(TIMEOUT_TICKS);
   localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO_W      = {WIDTH{1'b0}};

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;

   state_t           state_r, state_nxt_s;
   logic             sync1_r, echo_s_r, echo_d_r;
   logic             rise_s, fall_s;
   logic [WIDTH-1:0] pcnt_r, wcnt_r, tcnt_r;
   logic             publish_s, pub_timeout_s, accept_s;
   logic [WIDTH-1:0] pub_ticks_s;
   logic             trig_r, valid_r, timeout_r, overrun_r;
   logic [WIDTH-1:0] ticks_r;

   // Two-flop synchroniser on echo plus one delay stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r  <= 1'b0;
         echo_s_r <= 1'b0;
         echo_d_r <= 1'b0;
      end else begin
         sync1_r  <= echo_pin;
         echo_s_r <= sync1_r;
         echo_d_r <= echo_s_r;
      end
   end

   assign rise_s   = echo_s_r & ~echo_d_r;
   assign fall_s   = ~echo_s_r & echo_d_r;
   assign accept_s = valid_r & meas_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_nxt_s;
   end

   // FSM next-state logic; TRIG length is timed off the period counter
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) state_nxt_s = TRIG;
            else        state_nxt_s = IDLE;
         end
         TRIG: begin
            if (pcnt_r == TRIG_LAST) state_nxt_s = WAIT_RISE;
            else                     state_nxt_s = TRIG;
         end
         WAIT_RISE: begin
            if (rise_s)                 state_nxt_s = MEASURE;
            else if (wcnt_r == WAIT_LAST) state_nxt_s = HOLDOFF;
            else                        state_nxt_s = WAIT_RISE;
         end
         MEASURE: begin
            if (fall_s || (tcnt_r == TIMEOUT_W)) state_nxt_s = HOLDOFF;
            else                                 state_nxt_s = MEASURE;
         end
         HOLDOFF: begin
            if (pcnt_r == PERIOD_LAST) state_nxt_s = enable ? TRIG : IDLE;
            else                       state_nxt_s = HOLDOFF;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: result publication (a fall takes priority over the width timeout)
   always_comb begin
      publish_s     = 1'b0;
      pub_timeout_s = 1'b0;
      pub_ticks_s   = ZERO_W;
      case (state_r)
         WAIT_RISE: begin
            if (!rise_s && (wcnt_r == WAIT_LAST)) begin
               publish_s     = 1'b1;
               pub_timeout_s = 1'b1;
            end else begin
               publish_s = 1'b0;
            end
         end
         MEASURE: begin
            if (fall_s) begin
               publish_s   = 1'b1;
               pub_ticks_s = tcnt_r;
            end else if (tcnt_r == TIMEOUT_W) begin
               publish_s     = 1'b1;
               pub_timeout_s = 1'b1;
            end else begin
               publish_s = 1'b0;
            end
         end
         default: publish_s = 1'b0;
      endcase
   end

   // Period, rise-wait and echo-width counters
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_r <= ZERO_W;
         wcnt_r <= ZERO_W;
         tcnt_r <= ZERO_W;
      end else begin
         if (state_r == IDLE || pcnt_r == PERIOD_LAST) pcnt_r <= ZERO_W;
         else                                          pcnt_r <= pcnt_r + ONE_W;
         if (state_r == WAIT_RISE) wcnt_r <= wcnt_r + ONE_W;
         else                      wcnt_r <= ZERO_W;
         if (state_r == WAIT_RISE)                tcnt_r <= ONE_W;
         else if (state_r == MEASURE && echo_s_r) tcnt_r <= tcnt_r + ONE_W;
         else                                     tcnt_r <= tcnt_r;
      end
   end

   // Registered trigger and result holding register with overrun detection
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_r    <= 1'b0;
         valid_r   <= 1'b0;
         ticks_r   <= ZERO_W;
         timeout_r <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         trig_r <= (state_r == TRIG);
         if (publish_s) begin
            valid_r   <= 1'b1;
            ticks_r   <= pub_ticks_s;
            timeout_r <= pub_timeout_s;
            overrun_r <= valid_r & ~meas_ready;
         end else if (accept_s) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= 1'b0;
         end
      end
   end

   assign trig_pin     = trig_r;
   assign meas_valid   = valid_r;
   assign meas_ticks   = ticks_r;
   assign meas_timeout = timeout_r;
   assign overrun      = overrun_r;
endmodule
